alu_regfile_pipe: RTL
=====================

# alu_regfile_pipe

Parametrised successor to the 8-bit, 4-register ALU/register-file datapath. It generalises the operand width and register count and hardwires register 0 to zero. Instructions are issued through a valid/ready port; the block writes results back to the register file and queues them in a small output FIFO with its own valid/ready port. It sits between an instruction source (VIO or a future sequencer) and any result consumer (LEDs, monitor).

## Interface
- DATA_W, 8, operand/result/register width (≥4)
- NUM_REGS, 4, register count (power of 2, ≥2); ADDR_W = $clog2(NUM_REGS)
- OUT_DEPTH, 2, output FIFO entries (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted when in_valid && in_ready
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 BEQ
- rs1, rs2, rd  in  ADDR_W  source/destination registers
- imm  in  DATA_W  immediate operand
- use_imm  in  1  src2 = imm instead of reg[rs2]
- wb_en  in  1  write result to reg[rd] on accept
- dbg_wr_en, dbg_wr_addr (ADDR_W), dbg_wr_data (DATA_W)  in  direct register write
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops head when out_valid && out_ready
- result  out  DATA_W  head entry result (0 when empty)
- ovf  out  1  head entry signed overflow (0 when empty)
- take_branch  out  1  head entry branch flag (0 when empty)
- ovf_sticky  out  1  set by any accepted instruction with overflow
- ovf_clr  in  1  synchronous clear of ovf_sticky

## Operation
- Register read is combinational. reg[0] always reads 0, and writes to it are dropped. Other registers reset to 0.
- src1 = reg[rs1]; src2 = use_imm ? imm : reg[rs2].
- ADD/SUB: DATA_W-bit wrap-around result.
  - ovf = signed overflow: operand signs equal (ADD) or different (SUB), and the result sign differs from src1.
- AND/OR/XOR: bitwise, ovf=0.
- SLT: result = {0…,1} if $signed(src1) < $signed(src2), else 0.
- SLL: src1 << src2[$clog2(DATA_W)-1:0]; ovf=0.
- BEQ: result = src1 − src2, ovf=0, take_branch = (src1 == src2). take_branch=0 for all other ops.
- Accept (in_valid && in_ready):
  - the entry {result, ovf, take_branch} is pushed to the FIFO;
  - if wb_en && rd≠0, reg[rd] ← result at the same edge;
  - ovf_sticky ← 1 if ovf.
- in_ready = (count < OUT_DEPTH) || (out_valid && out_ready), i.e. push into a full FIFO is allowed in a simultaneous-pop cycle.
- FIFO: circular buffer with read pointer, write pointer and count; pointers wrap at OUT_DEPTH. Simultaneous push and pop leaves count unchanged.
- dbg_wr_en writes reg[dbg_wr_addr] independent of in_valid. Same-cycle collision with an accepted wb_en to the same rd: the instruction write wins.
- ovf_clr and a same-cycle overflow set: the set wins.
- Reset (async, reset=0), immediate regardless of activity:
  - all registers 0, FIFO emptied, ovf_sticky 0;
  - out_valid/result/ovf/take_branch = 0, in_ready = 1.

## Timing
- Issue-to-output latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N if the FIFO was empty.
- Writeback visible to reads after the accepting edge. Back-to-back dependent instructions need no stall or forwarding.
- Throughput: 1 instruction/cycle while out_ready=1.
- out_* are held stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready only; there is no path from in_valid to in_ready.

## Test plan
- Reset with FIFO full and regs loaded, reset=0 mid-cycle → outputs 0, out_valid=0, in_ready=1 immediately; all regs read 0 after release.
- Overflow: dbg write r1=0x7F, r2=0x01; ADD rd=3 → result 0x80, ovf=1, ovf_sticky=1. Then SUB r3−r2 → 0x7F, ovf=1. Pulse ovf_clr → ovf_sticky=0.
- Back-pressure (OUT_DEPTH=2): out_ready=0, issue 3 instructions → 2 accepted, then in_ready=0. Assert out_ready with in_valid=1 → pop and push in the same cycle, count stays 2, entries emerge in order.
- Zero register: dbg write r0=0xFF and ADD imm 0x05 with rd=0, wb_en=1 → reg[0] still reads 0. ADD r0+imm 0x05 → result 0x05.
- Dependency and branch: back-to-back `r2 ← r1+imm 1` (r1=0x10) then BEQ r2 vs imm 0x11 → take_branch=1, result 0. SLT r1(0x80) vs r2(0x01) → result 1.
- Collision: dbg_wr to r2=0xAA in the same cycle as accepted wb to r2=0x11 → r2=0x11.

Source files
------------

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe
// ----------------
// Parametrised ALU + register-file datapath with a valid/ready instruction
// port and a small result FIFO with its own valid/ready port.
//
// Register 0 is hardwired to zero: it always reads zero and writes to it are
// dropped. Register reads are combinational, so a result written back at an
// accepting edge is seen by the next instruction without stalls.
//
// Ports
//   clk, reset                 clock (rising edge) and async active-low reset
//   in_valid / in_ready        instruction handshake
//   op, rs1, rs2, rd           opcode and register addresses
//   imm, use_imm               immediate operand and src2 select
//   wb_en                      write result back to reg[rd] on accept
//   dbg_wr_en/addr/data        direct register write port
//   out_valid / out_ready      result FIFO handshake
//   result, ovf, take_branch   FIFO head entry (all zero while empty)
//   ovf_sticky, ovf_clr        accumulated overflow flag and its clear
module alu_regfile_pipe #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 4,
    parameter int OUT_DEPTH = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic              wb_en,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_wr_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              take_branch,
    output logic              ovf_sticky,
    input  logic              ovf_clr
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int MSB   = DATA_W - 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_BEQ = 3'd7;

    // Circular-buffer pointer advance, wrapping at OUT_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1'b1));
    endfunction

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] fifo_res_r [OUT_DEPTH];
    logic              fifo_ovf_r [OUT_DEPTH];
    logic              fifo_br_r  [OUT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              sticky_r;

    logic [DATA_W-1:0] src1_s;
    logic [DATA_W-1:0] src2_s;
    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ovf_s;
    logic              alu_br_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;

    assign sum_s  = src1_s + src2_s;
    assign diff_s = src1_s - src2_s;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s       = out_valid_s && out_ready;
    assign in_ready    = (count_r < CNT_FULL) || pop_s;
    assign push_s      = in_valid && in_ready;

    // Operand fetch; reg[0] forced to zero on read.
    always_comb begin
        src1_s = DATA_ZERO;
        src2_s = DATA_ZERO;
        if (rs1 == ADDR_ZERO) begin
            src1_s = DATA_ZERO;
        end else begin
            src1_s = regs_r[rs1];
        end
        if (use_imm) begin
            src2_s = imm;
        end else if (rs2 == ADDR_ZERO) begin
            src2_s = DATA_ZERO;
        end else begin
            src2_s = regs_r[rs2];
        end
    end

    // ALU: result, signed overflow and branch flag for the current instruction.
    always_comb begin
        alu_res_s = DATA_ZERO;
        alu_ovf_s = 1'b0;
        alu_br_s  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (src1_s[MSB] == src2_s[MSB]) && (sum_s[MSB] != src1_s[MSB]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (src1_s[MSB] != src2_s[MSB]) && (diff_s[MSB] != src1_s[MSB]);
            end
            OP_AND: alu_res_s = src1_s & src2_s;
            OP_OR:  alu_res_s = src1_s | src2_s;
            OP_XOR: alu_res_s = src1_s ^ src2_s;
            OP_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(src1_s) < $signed(src2_s))};
            OP_SLL: alu_res_s = src1_s << src2_s[SH_W-1:0];
            OP_BEQ: begin
                alu_res_s = diff_s;
                alu_br_s  = (src1_s == src2_s);
            end
            default: begin
                alu_res_s = DATA_ZERO;
                alu_ovf_s = 1'b0;
                alu_br_s  = 1'b0;
            end
        endcase
    end

    // Register file: instruction writeback has priority over the debug port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_ZERO;
            end
        end else begin
            regs_r[0] <= DATA_ZERO;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (push_s && wb_en && (rd == ADDR_W'(i))) begin
                    regs_r[i] <= alu_res_s;
                end else if (dbg_wr_en && (dbg_wr_addr == ADDR_W'(i))) begin
                    regs_r[i] <= dbg_wr_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // FIFO pointers and occupancy; push+pop together keeps the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage written at the write pointer on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_res_r[i] <= DATA_ZERO;
                fifo_ovf_r[i] <= 1'b0;
                fifo_br_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            fifo_res_r[wr_ptr_r] <= alu_res_s;
            fifo_ovf_r[wr_ptr_r] <= alu_ovf_s;
            fifo_br_r[wr_ptr_r]  <= alu_br_s;
        end
    end

    // Sticky overflow: a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_r <= 1'b0;
        end else if (push_s && alu_ovf_s) begin
            sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            sticky_r <= 1'b0;
        end
    end

    // Head-of-FIFO outputs, masked to zero while the FIFO is empty.
    always_comb begin
        result      = DATA_ZERO;
        ovf         = 1'b0;
        take_branch = 1'b0;
        if (out_valid_s) begin
            result      = fifo_res_r[rd_ptr_r];
            ovf         = fifo_ovf_r[rd_ptr_r];
            take_branch = fifo_br_r[rd_ptr_r];
        end else begin
            result      = DATA_ZERO;
            ovf         = 1'b0;
            take_branch = 1'b0;
        end
    end

    assign out_valid  = out_valid_s;
    assign ovf_sticky = sticky_r;

endmodule
